fc_neuron_scheduler: RTL and testbench

//  Sequencer wrapped around a bank of fully-connected neuron datapaths.

---
 rtl/fc_neuron_scheduler.sv | 125 ++++++++++++
 tb/tb_fc_neuron_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_scheduler.sv
// Frame sequencer for a fully-connected neuron bank: gathers an input vector, holds it
// for the bank over a settle window, snapshots every neuron result and streams them out in order.
module fc_snap_lane #(
    parameter int OW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [OW-1:0] d,
    output logic [OW-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
    end
endmodule

module fc_neuron_scheduler #(
    parameter  int WIDTH   = 8,
    parameter  int IN      = 128,
    parameter  int NEURONS = 10,
    parameter  int SETTLE  = 2,
    localparam int OW      = WIDTH*2 + $clog2(IN),
    localparam int IDXW    = $clog2(NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [IN*WIDTH-1:0]   x_bus,
    input  logic [NEURONS*OW-1:0] z_bus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OW-1:0]         out_data,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_last,
    output logic                  busy
);
    localparam int PW = $clog2(IN);
    localparam int CW = 4;

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_EMIT} state_t;

    state_t                       state;
    logic [PW-1:0]                wr_ptr;
    logic [CW-1:0]                settle_cnt;
    logic [IDXW-1:0]              rd_idx;
    logic [IN-1:0][WIDTH-1:0]     xbuf;
    logic [NEURONS-1:0][OW-1:0]   z_arr;
    logic [NEURONS-1:0][OW-1:0]   snap_arr;
    logic                         snap_load;

    assign x_bus     = xbuf;
    assign z_arr     = z_bus;
    // Snapshot only on the final settle cycle, so later z_bus motion never reaches out_data.
    assign snap_load = (state == S_SETTLE) && (settle_cnt == '0) && !clear;

    for (genvar n = 0; n < NEURONS; n++) begin : g_lane
        fc_snap_lane #(.OW(OW)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (snap_load),
            .d    (z_arr[n]),
            .q    (snap_arr[n])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            wr_ptr     <= '0;
            settle_cnt <= '0;
            rd_idx     <= '0;
            xbuf       <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else if (clear) begin
            state      <= S_LOAD;
            wr_ptr     <= '0;
            settle_cnt <= '0;
            rd_idx     <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: if (in_valid) begin
                    xbuf[wr_ptr] <= in_data;
                    if (wr_ptr == PW'(IN-1)) begin
                        wr_ptr     <= '0;
                        settle_cnt <= CW'(SETTLE-1);
                        in_ready   <= 1'b0;
                        state      <= S_SETTLE;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                S_SETTLE: if (settle_cnt == '0) begin
                    rd_idx    <= '0;
                    out_valid <= 1'b1;
                    state     <= S_EMIT;
                end else begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                S_EMIT: if (out_ready) begin
                    if (rd_idx == IDXW'(NEURONS-1)) begin
                        rd_idx    <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign out_data = snap_arr[rd_idx];
    assign out_idx  = rd_idx;
    assign out_last = out_valid && (rd_idx == IDXW'(NEURONS-1));
    assign busy     = (state != S_LOAD) || (wr_ptr != '0);
endmodule

// File: tb/tb_fc_neuron_scheduler.sv
// Bench for fc_neuron_scheduler: a behavioural neuron bank drives z_bus from x_bus, and each
// emitted result is compared against the same neuron function applied to the frame the bench sent.
module tb_fc_neuron_scheduler;
    localparam int WIDTH   = 8;
    localparam int IN      = 128;
    localparam int NEURONS = 10;
    localparam int OW      = WIDTH*2 + $clog2(IN);
    localparam int IDXW    = $clog2(NEURONS);

    logic clk = 1'b0;
    logic rst, clear, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [WIDTH-1:0]      in_data;
    logic [IN*WIDTH-1:0]   x_bus;
    logic [NEURONS*OW-1:0] z_bus;
    logic [OW-1:0]         out_data;
    logic [IDXW-1:0]       out_idx;

    // Two extra builds with the extreme settle windows, fed by their own stimulus.
    logic                  aux_valid, aux_clear;
    logic [WIDTH-1:0]      aux_data;
    logic [NEURONS*OW-1:0] aux_z;
    logic                  a_ir   [2];
    logic                  a_ov   [2];
    logic                  a_last [2];
    logic                  a_busy [2];
    logic [OW-1:0]         a_od   [2];
    logic [IDXW-1:0]       a_idx  [2];
    logic [IN*WIDTH-1:0]   a_x    [2];

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    fc_neuron_scheduler #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x_bus(x_bus), .z_bus(z_bus), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy));

    fc_neuron_scheduler #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst(rst), .clear(aux_clear), .in_valid(aux_valid), .in_ready(a_ir[0]),
        .in_data(aux_data), .x_bus(a_x[0]), .z_bus(aux_z), .out_valid(a_ov[0]),
        .out_ready(1'b1), .out_data(a_od[0]), .out_idx(a_idx[0]), .out_last(a_last[0]),
        .busy(a_busy[0]));

    fc_neuron_scheduler #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .SETTLE(15)) dut_s15 (
        .clk(clk), .rst(rst), .clear(aux_clear), .in_valid(aux_valid), .in_ready(a_ir[1]),
        .in_data(aux_data), .x_bus(a_x[1]), .z_bus(aux_z), .out_valid(a_ov[1]),
        .out_ready(1'b1), .out_data(a_od[1]), .out_idx(a_idx[1]), .out_last(a_last[1]),
        .busy(a_busy[1]));

    // Behavioural neuron: small signed constant weights, dot product, ReLU.
    function automatic int wgt(input int n, input int i);
        return ((n*7 + i*3) % 5) - 2;
    endfunction

    function automatic logic [OW-1:0] relu_dot(input logic [IN*WIDTH-1:0] xv, input int n);
        int s = 0;
        for (int i = 0; i < IN; i++) s += int'(xv[i*WIDTH +: WIDTH]) * wgt(n, i);
        return (s < 0) ? '0 : OW'(s);
    endfunction

    function automatic logic [OW-1:0] zpat(input int n);
        case (n % 3)
            0:       return '0;
            1:       return {OW{1'b1}};
            default: return OW'(n*12345);
        endcase
    endfunction

    bit perturb;
    always_comb begin
        z_bus = '0;
        aux_z = '0;
        for (int n = 0; n < NEURONS; n++) begin
            z_bus[n*OW +: OW] = relu_dot(x_bus, n) ^ (perturb ? OW'(n*37 + 1) : OW'(0));
            aux_z[n*OW +: OW] = zpat(n);
        end
    end

    int acc_cnt = 0;
    always @(posedge clk)
        if (!rst && !clear && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

    logic [WIDTH-1:0] frame [IN];
    logic [OW-1:0]    exp_z [NEURONS];

    task automatic rand_frame();
        for (int i = 0; i < IN; i++) frame[i] = WIDTH'($urandom);
    endtask

    task automatic set_exp();
        logic [IN*WIDTH-1:0] fv;
        for (int i = 0; i < IN; i++) fv[i*WIDTH +: WIDTH] = frame[i];
        for (int n = 0; n < NEURONS; n++) exp_z[n] = relu_dot(fv, n);
    endtask

    task automatic load_frame(input bit gaps, input int nwords);
        int k = 0;
        int guard = 0;
        while (k < nwords && guard < 4*IN) begin
            @(negedge clk);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = frame[k];
            if (in_valid && in_ready) k++;
            guard++;
        end
        chk("load_words", 64'(k), 64'(nwords));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edge count includes the edge that accepted the last word.
    task automatic wait_valid(input int exp_edges);
        int e = 1;
        while (!out_valid && e < 40) begin
            @(posedge clk);
            #1 e++;
        end
        chk("latency", 64'(e), 64'(exp_edges));
    endtask

    task automatic emit_check(input int bp_idx, input int bp_len, input int clr_idx, input bit rnd);
        int nx = 0;
        int hold = 0;
        int guard = 0;
        while (nx < NEURONS && guard < 200) begin
            @(negedge clk);
            guard++;
            if (out_valid && nx == clr_idx) begin
                chk("pre_clr_idx", 64'(out_idx), 64'(clr_idx));
                clear = 1'b1;
                out_ready = 1'b1;
                @(posedge clk);
                #1 clear = 1'b0;
                chk("clr_valid", 64'(out_valid), 64'(0));
                chk("clr_ready", 64'(in_ready), 64'(1));
                chk("clr_idx", 64'(out_idx), 64'(0));
                chk("clr_busy", 64'(busy), 64'(0));
                return;
            end
            if (out_valid && int'(out_idx) == bp_idx && hold < bp_len) begin
                out_ready = 1'b0;
                perturb = 1'b1;
                hold++;
                chk("bp_idx", 64'(out_idx), 64'(bp_idx));
                chk("bp_data", 64'(out_data), 64'(exp_z[bp_idx]));
            end else begin
                perturb = 1'b0;
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("out_idx", 64'(out_idx), 64'(nx));
                chk("out_data", 64'(out_data), 64'(exp_z[nx]));
                chk("out_last", 64'(out_last), 64'(nx == NEURONS-1));
                nx++;
            end
        end
        chk("emit_count", 64'(nx), 64'(NEURONS));
        @(posedge clk);
        #1;
        chk("post_ready", 64'(in_ready), 64'(1));
        chk("post_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
    endtask

    task automatic run_frame(input bit gaps, input int bp_idx, input int bp_len, input bit rnd);
        set_exp();
        load_frame(gaps, IN);
        wait_valid(3);
        emit_check(bp_idx, bp_len, -1, rnd);
    endtask

    task automatic aux_watch(input int a, input int settle);
        int e = 1;
        while (!a_ov[a] && e < 40) begin
            @(posedge clk);
            #1 e++;
        end
        chk($sformatf("aux%0d_latency", a), 64'(e), 64'(settle + 1));
        for (int n = 0; n < NEURONS; n++) begin
            chk($sformatf("aux%0d_idx", a), 64'(a_idx[a]), 64'(n));
            chk($sformatf("aux%0d_data", a), 64'(a_od[a]), 64'(zpat(n)));
            chk($sformatf("aux%0d_last", a), 64'(a_last[a]), 64'(n == NEURONS-1));
            @(posedge clk);
            #1;
        end
        chk($sformatf("aux%0d_done", a), 64'(a_ov[a]), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a0, bad;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        perturb = 1'b0; aux_valid = 1'b0; aux_data = '0; aux_clear = 1'b0;
        #3;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_idx", 64'(out_idx), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_xbus", 64'(x_bus == '0), 64'(1));
        @(negedge clk) rst = 1'b0;

        // reset in the middle of a frame
        rand_frame();
        load_frame(1'b0, 57);
        chk("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #2;
        chk("mrst_ready", 64'(in_ready), 64'(1));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_xbus", 64'(x_bus == '0), 64'(1));
        @(negedge clk) rst = 1'b0;

        // ramp frame, no backpressure
        for (int i = 0; i < IN; i++) frame[i] = WIDTH'(i & 8'hFF);
        set_exp();
        load_frame(1'b0, IN);
        chk("xbus_w5", 64'(x_bus[5*WIDTH +: WIDTH]), 64'(5));
        chk("settle_ready", 64'(in_ready), 64'(0));
        chk("settle_busy", 64'(busy), 64'(1));
        wait_valid(3);
        emit_check(-1, 0, -1, 1'b0);

        // backpressure at idx 3 with z_bus perturbed
        rand_frame();
        run_frame(1'b0, 3, 4, 1'b0);

        // gapped input, random downstream ready
        rand_frame();
        set_exp();
        a0 = acc_cnt;
        load_frame(1'b1, IN);
        chk("accepts", 64'(acc_cnt - a0), 64'(IN));
        chk("gap_ready", 64'(in_ready), 64'(0));
        bad = 0;
        for (int i = 0; i < IN; i++) if (x_bus[i*WIDTH +: WIDTH] !== frame[i]) bad++;
        chk("x_order", 64'(bad), 64'(0));
        wait_valid(3);
        emit_check(-1, 0, -1, 1'b1);

        // clear at wr_ptr 100, coincident with an offered word
        rand_frame();
        load_frame(1'b0, 100);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        chk("clrload_busy", 64'(busy), 64'(0));
        chk("clrload_ready", 64'(in_ready), 64'(1));
        rand_frame();
        run_frame(1'b0, -1, 0, 1'b0);

        // clear during emit at idx 4, then a normal frame
        rand_frame();
        set_exp();
        load_frame(1'b0, IN);
        wait_valid(3);
        emit_check(-1, 0, 4, 1'b0);
        rand_frame();
        run_frame(1'b1, -1, 0, 1'b1);

        // extreme settle windows, z at 0 and all-ones
        for (int k = 0; k < IN; k++) begin
            @(negedge clk);
            aux_valid = 1'b1;
            aux_data = WIDTH'($urandom);
        end
        @(posedge clk);
        #1 aux_valid = 1'b0;
        fork
            aux_watch(0, 1);
            aux_watch(1, 15);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
